// File: rtl/bypass_scoreboard_unit.sv
// Operand bypass network plus long-latency busy-bit scoreboard for one register file.
// Each source operand owns a registered one-hot select; the scoreboard is shared.

module bypass_scoreboard_operand #(
  parameter int XLEN           = 32,
  parameter int NUM_FWD_STAGES = 2,
  parameter int NUM_REGS       = 32,
  parameter int RW             = 5,
  parameter int HAS_X0         = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           stall_in,
  input  logic                           flush,
  input  logic                           valid_early,
  input  logic [RW-1:0]                  addr_early,
  input  logic [XLEN-1:0]                rf_data,
  input  logic [NUM_FWD_STAGES-1:0]      prod_wr_en,
  input  logic [NUM_FWD_STAGES*RW-1:0]   prod_rd,
  input  logic [NUM_FWD_STAGES*XLEN-1:0] fwd_data,
  input  logic [NUM_FWD_STAGES-1:0]      fwd_ready,
  input  logic                           lat_wb_en,
  input  logic [RW-1:0]                  lat_wb_rd,
  input  logic [XLEN-1:0]                lat_wb_data,
  input  logic [NUM_REGS-1:0]            busy,
  output logic [XLEN-1:0]                value,
  output logic                           stall_req
);
  logic [NUM_FWD_STAGES-1:0] hit, sel_d, sel_q;
  logic                      is_x0_q, valid_q, addr_zero, wb_hit, found;
  logic [RW-1:0]             addr_q;
  logic [XLEN-1:0]           fwd_val;

  assign addr_zero = (HAS_X0 != 0) && (addr_early == '0);

  for (genvar k = 0; k < NUM_FWD_STAGES; k++) begin : g_hit
    assign hit[k] = valid_early && prod_wr_en[k] && !addr_zero &&
                    (prod_rd[k*RW +: RW] == addr_early);
  end

  // Youngest producer (lowest slot) owns the value.
  always_comb begin
    sel_d = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_FWD_STAGES; k++) begin
      if (hit[k] && !found) begin
        sel_d[k] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q   <= '0;
      is_x0_q <= 1'b0;
      valid_q <= 1'b0;
      addr_q  <= '0;
    end else if (flush) begin
      sel_q   <= '0;
      valid_q <= 1'b0;
    end else if (!stall_in) begin
      sel_q   <= sel_d;
      is_x0_q <= addr_zero;
      valid_q <= valid_early;
      addr_q  <= addr_early;
    end
  end

  assign wb_hit = lat_wb_en && (lat_wb_rd == addr_q);

  // Forwarded data is taken live so a late load fills in while the pipe is held.
  always_comb begin
    fwd_val = '0;
    for (int k = 0; k < NUM_FWD_STAGES; k++)
      if (sel_q[k]) fwd_val = fwd_data[k*XLEN +: XLEN];
    if (is_x0_q)     value = '0;
    else if (|sel_q) value = fwd_val;
    else if (wb_hit) value = lat_wb_data;
    else             value = rf_data;
  end

  assign stall_req = valid_q && ((|(sel_q & ~fwd_ready)) ||
                                 (busy[addr_q] && !(|sel_q) && !wb_hit));
endmodule

module bypass_scoreboard_unit #(
  parameter int  XLEN           = 32,
  parameter int  NUM_SRC        = 3,
  parameter int  NUM_FWD_STAGES = 2,
  parameter int  NUM_REGS       = 32,
  parameter int  HAS_X0         = 1,
  localparam int RW             = $clog2(NUM_REGS)
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_stall,
  input  logic                           i_flush,
  input  logic [NUM_SRC-1:0]             i_src_valid_early,
  input  logic [NUM_SRC*RW-1:0]          i_src_addr_early,
  input  logic [NUM_SRC*XLEN-1:0]        i_rf_data,
  input  logic [NUM_FWD_STAGES-1:0]      i_prod_wr_en,
  input  logic [NUM_FWD_STAGES*RW-1:0]   i_prod_rd,
  input  logic [NUM_FWD_STAGES*XLEN-1:0] i_fwd_data,
  input  logic [NUM_FWD_STAGES-1:0]      i_fwd_data_ready,
  input  logic                           i_lat_issue,
  input  logic [RW-1:0]                  i_lat_rd,
  input  logic                           i_lat_wb_en,
  input  logic [RW-1:0]                  i_lat_wb_rd,
  input  logic [XLEN-1:0]                i_lat_wb_data,
  output logic [NUM_SRC*XLEN-1:0]        o_src_value,
  output logic                           o_stall_req,
  output logic                           o_waw_stall,
  output logic [NUM_REGS-1:0]            o_busy_vec
);
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [NUM_SRC-1:0]  stall_vec;
  logic                wb_same, accept;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    bypass_scoreboard_operand #(
      .XLEN(XLEN), .NUM_FWD_STAGES(NUM_FWD_STAGES), .NUM_REGS(NUM_REGS),
      .RW(RW), .HAS_X0(HAS_X0)
    ) u_op (
      .clk         (i_clk),
      .rst         (i_rst),
      .stall_in    (i_stall),
      .flush       (i_flush),
      .valid_early (i_src_valid_early[s]),
      .addr_early  (i_src_addr_early[s*RW +: RW]),
      .rf_data     (i_rf_data[s*XLEN +: XLEN]),
      .prod_wr_en  (i_prod_wr_en),
      .prod_rd     (i_prod_rd),
      .fwd_data    (i_fwd_data),
      .fwd_ready   (i_fwd_data_ready),
      .lat_wb_en   (i_lat_wb_en),
      .lat_wb_rd   (i_lat_wb_rd),
      .lat_wb_data (i_lat_wb_data),
      .busy        (busy_q),
      .value       (o_src_value[s*XLEN +: XLEN]),
      .stall_req   (stall_vec[s])
    );
  end

  assign o_stall_req = |stall_vec;

  // A writeback landing on the same edge frees the register, so that issue is not a WAW.
  assign wb_same     = i_lat_wb_en && (i_lat_wb_rd == i_lat_rd);
  assign o_waw_stall = i_lat_issue && busy_q[i_lat_rd] && !wb_same;
  assign accept      = i_lat_issue && !o_waw_stall && !((HAS_X0 != 0) && (i_lat_rd == '0));

  always_comb begin
    busy_d = busy_q;
    if (i_lat_wb_en) busy_d[i_lat_wb_rd] = 1'b0;
    if (accept)      busy_d[i_lat_rd]    = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign o_busy_vec = busy_q;
endmodule

// File: tb/tb_bypass_scoreboard_unit.sv
// Queue-based bench: expectations are queued as stimulus is applied and drained at sample time.
module tb_bypass_scoreboard_unit;
  localparam int XLEN = 32, NS = 3, NF = 2, NR = 32, RW = 5;

  logic i_clk = 1'b0, i_rst = 1'b1, i_stall, i_flush;
  logic [NS-1:0]      src_valid_early;
  logic [NS*RW-1:0]   src_addr_early;
  logic [NS*XLEN-1:0] rf_data;
  logic [NF-1:0]      prod_wr_en, fwd_ready;
  logic [NF*RW-1:0]   prod_rd;
  logic [NF*XLEN-1:0] fwd_data;
  logic               lat_issue, lat_wb_en;
  logic [RW-1:0]      lat_rd, lat_wb_rd;
  logic [XLEN-1:0]    lat_wb_data;
  logic [NS*XLEN-1:0] src_value, src_value_nx;
  logic               stall_req, waw_stall, stall_req_nx, waw_stall_nx;
  logic [NR-1:0]      busy_vec, busy_vec_nx;

  always #5 i_clk = ~i_clk;

  bypass_scoreboard_unit #(.XLEN(XLEN), .NUM_SRC(NS), .NUM_FWD_STAGES(NF), .NUM_REGS(NR), .HAS_X0(1)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_stall(i_stall), .i_flush(i_flush),
    .i_src_valid_early(src_valid_early), .i_src_addr_early(src_addr_early), .i_rf_data(rf_data),
    .i_prod_wr_en(prod_wr_en), .i_prod_rd(prod_rd), .i_fwd_data(fwd_data), .i_fwd_data_ready(fwd_ready),
    .i_lat_issue(lat_issue), .i_lat_rd(lat_rd), .i_lat_wb_en(lat_wb_en), .i_lat_wb_rd(lat_wb_rd),
    .i_lat_wb_data(lat_wb_data), .o_src_value(src_value), .o_stall_req(stall_req),
    .o_waw_stall(waw_stall), .o_busy_vec(busy_vec));

  bypass_scoreboard_unit #(.XLEN(XLEN), .NUM_SRC(NS), .NUM_FWD_STAGES(NF), .NUM_REGS(NR), .HAS_X0(0)) dut_nx (
    .i_clk(i_clk), .i_rst(i_rst), .i_stall(i_stall), .i_flush(i_flush),
    .i_src_valid_early(src_valid_early), .i_src_addr_early(src_addr_early), .i_rf_data(rf_data),
    .i_prod_wr_en(prod_wr_en), .i_prod_rd(prod_rd), .i_fwd_data(fwd_data), .i_fwd_data_ready(fwd_ready),
    .i_lat_issue(lat_issue), .i_lat_rd(lat_rd), .i_lat_wb_en(lat_wb_en), .i_lat_wb_rd(lat_wb_rd),
    .i_lat_wb_data(lat_wb_data), .o_src_value(src_value_nx), .o_stall_req(stall_req_nx),
    .o_waw_stall(waw_stall_nx), .o_busy_vec(busy_vec_nx));

  typedef struct { string tag; int kind; int idx; logic [31:0] val; } exp_t;
  exp_t exp_q[$];
  int n_pass = 0, n_total = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, want);
  endtask

  // kind: 0 value, 1 stall_req, 2 busy_vec, 3 waw_stall, 4 value of HAS_X0=0 instance
  task automatic push(input string tag, input int kind, input int idx, input logic [31:0] val);
    exp_t e;
    e.tag = tag; e.kind = kind; e.idx = idx; e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] got;
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.kind)
        0:       got = src_value[e.idx*XLEN +: XLEN];
        1:       got = {31'b0, stall_req};
        2:       got = busy_vec;
        3:       got = {31'b0, waw_stall};
        default: got = src_value_nx[e.idx*XLEN +: XLEN];
      endcase
      chk(e.tag, got, e.val);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_early();
    src_valid_early = '0; src_addr_early = '0; prod_wr_en = '0; prod_rd = '0;
  endtask

  task automatic read_src(input int s, input logic [RW-1:0] a);
    src_valid_early[s] = 1'b1;
    src_addr_early[s*RW +: RW] = a;
  endtask

  task automatic produce(input int k, input logic [RW-1:0] a);
    prod_wr_en[k] = 1'b1;
    prod_rd[k*RW +: RW] = a;
  endtask

  initial begin
    i_stall = 0; i_flush = 0; idle_early();
    rf_data = {32'hC0C0_0002, 32'hB0B0_0001, 32'hA0A0_0000};
    fwd_data = '0; fwd_ready = '1;
    lat_issue = 0; lat_rd = '0; lat_wb_en = 0; lat_wb_rd = '0; lat_wb_data = '0;
    #12 i_rst = 1'b0;
    push("rst_v0", 0, 0, 32'hA0A0_0000); push("rst_v1", 0, 1, 32'hB0B0_0001);
    push("rst_v2", 0, 2, 32'hC0C0_0002); push("rst_stall", 1, 0, 0);
    push("rst_waw", 3, 0, 0); push("rst_busy", 2, 0, 0);
    drain();

    // back-to-back ALU: EX and WB both write x5, slot 0 wins
    read_src(1, 5); produce(0, 5); produce(1, 5);
    tick(); idle_early();
    fwd_data = {32'h0000_AAAA, 32'h0000_1234};
    push("alu_slot0", 0, 1, 32'h1234); push("alu_nostall", 1, 0, 0);
    drain();
    read_src(1, 5); produce(1, 5);
    tick(); idle_early();
    push("alu_slot1", 0, 1, 32'hAAAA);
    drain();

    // load-use: slot 0 not ready for 3 cycles, value follows live data
    read_src(0, 7); produce(0, 7);
    tick(); idle_early();
    i_stall = 1; fwd_ready = 2'b10;
    for (int c = 0; c < 3; c++) begin
      fwd_data[31:0] = 32'h1000 + c;
      push("lu_stall", 1, 0, 1); push("lu_live", 0, 0, 32'h1000 + c);
      drain();
      tick();
    end
    fwd_ready = '1; fwd_data[31:0] = 32'h0BAD_F00D;
    push("lu_release", 1, 0, 0); push("lu_value", 0, 0, 32'h0BAD_F00D);
    drain();
    i_stall = 0; tick();

    // x0: hardwired zero vs HAS_X0=0 instance
    read_src(2, 0); produce(0, 0);
    tick(); idle_early();
    fwd_data[31:0] = 32'hFFFF_FFFF; rf_data[95:64] = 32'h5555_5555;
    push("x0_zero", 0, 2, 0); push("x0_nostall", 1, 0, 0); push("nx_fwd", 4, 2, 32'hFFFF_FFFF);
    drain();

    // flush has priority over stall and clears the select
    read_src(1, 4); produce(0, 4);
    tick();
    i_stall = 1; i_flush = 1;
    tick(); idle_early(); i_flush = 0;
    fwd_data[31:0] = 32'hEEEE; fwd_ready = 2'b10;
    push("flush_val", 0, 1, 32'hB0B0_0001); push("flush_nostall", 1, 0, 0);
    drain();
    i_stall = 0; fwd_ready = '1; tick();

    // scoreboard: div to x9, consumer stalls until writeback
    lat_issue = 1; lat_rd = 9;
    push("div_waw0", 3, 0, 0);
    drain();
    tick(); lat_issue = 0;
    push("div_busy", 2, 0, 32'h1 << 9);
    drain();
    read_src(0, 9);
    tick(); idle_early();
    i_stall = 1; rf_data[31:0] = 32'h1111;
    push("div_stall", 1, 0, 1); push("div_rfval", 0, 0, 32'h1111);
    drain();
    tick();
    push("div_stall2", 1, 0, 1);
    drain();
    lat_wb_en = 1; lat_wb_rd = 9; lat_wb_data = 32'hD1D1_D1D1;
    push("wb_nostall", 1, 0, 0); push("wb_val", 0, 0, 32'hD1D1_D1D1); push("wb_busy_held", 2, 0, 32'h1 << 9);
    drain();
    tick(); lat_wb_en = 0;
    push("wb_cleared", 2, 0, 0); push("wb_after", 1, 0, 0);
    drain();
    i_stall = 0; tick();

    // WAW and same-edge issue/writeback
    lat_issue = 1; lat_rd = 9;
    tick();
    push("waw_hit", 3, 0, 1);
    drain();
    tick(); lat_issue = 0;
    push("waw_busy", 2, 0, 32'h1 << 9);
    drain();
    lat_issue = 1; lat_rd = 9; lat_wb_en = 1; lat_wb_rd = 9;
    push("same_nowaw", 3, 0, 0);
    drain();
    tick(); lat_issue = 0; lat_wb_en = 0;
    push("same_busy", 2, 0, 32'h1 << 9);
    drain();
    lat_issue = 1; lat_rd = 0;
    tick(); lat_issue = 0;
    push("x0_never_busy", 2, 0, 32'h1 << 9);
    drain();

    // async reset mid-stall with busy bits set
    read_src(0, 9);
    tick(); idle_early();
    i_stall = 1; rf_data = {32'h3333, 32'h2222, 32'h1111};
    push("pre_rst_stall", 1, 0, 1);
    drain();
    i_rst = 1;
    push("arst_busy", 2, 0, 0); push("arst_stall", 1, 0, 0);
    push("arst_v0", 0, 0, 32'h1111); push("arst_v1", 0, 1, 32'h2222); push("arst_v2", 0, 2, 32'h3333);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/bypass_scoreboard_unit.md
Name: bypass_scoreboard_unit

Overview:
- Parametrised successor to the integer forwarding unit.
- Bypasses results from N pipeline stages to S source operands in EX, using registered per-operand select vectors.
- Tracks registers with pending long-latency writes (divider/FPU) on a busy-bit scoreboard, bypasses their late writeback, and raises a stall request when a needed operand is not yet available.
- One instance per register file (HAS_X0=1 for integer, 0 for FP).

Parameters:
XLEN, 32, operand width
NUM_SRC, 3, source operands per instruction (3 covers FMA)
NUM_FWD_STAGES, 2, bypass slots (slot k = stage k+1 after EX; 0=MA, 1=WB)
NUM_REGS, 32, architectural registers; RW = $clog2(NUM_REGS)
HAS_X0, 1, register 0 hardwired to zero

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous active-high reset
i_stall  in  1  pipeline hold; selects and x0 flags keep their value
i_flush  in  1  clear selects (EX gets bubble)
i_src_valid_early  in  NUM_SRC  operand used by instruction entering EX next edge
i_src_addr_early  in  NUM_SRC*RW  early source addresses from PD/ID
i_rf_data  in  NUM_SRC*XLEN  regfile values registered at ID->EX
i_prod_wr_en  in  NUM_FWD_STAGES  producer in stage k (0=EX) writes this regfile
i_prod_rd  in  NUM_FWD_STAGES*RW  producer destination, stage k
i_fwd_data  in  NUM_FWD_STAGES*XLEN  live result data of slot k
i_fwd_data_ready  in  NUM_FWD_STAGES  slot k data valid (0 = load/MMIO outstanding)
i_lat_issue  in  1  long-latency op issued this cycle
i_lat_rd  in  RW  its destination
i_lat_wb_en  in  1  long-latency writeback this cycle
i_lat_wb_rd  in  RW  writeback destination
i_lat_wb_data  in  XLEN  writeback data
o_src_value  out  NUM_SRC*XLEN  resolved operand values to EX
o_stall_req  out  1  operand unavailable; hold pipeline
o_waw_stall  out  1  i_lat_issue targets busy register; issue ignored
o_busy_vec  out  NUM_REGS  scoreboard state

Behaviour:
- Async reset clears all selects, x0 flags, src_valid registers and busy bits.
- After reset: o_src_value = i_rf_data; o_stall_req = 0; o_waw_stall = 0; o_busy_vec = 0.
- Select register (one-hot per operand): at posedge with !i_stall, sel[s][k] <= hit(s,k) && no hit(s,j) for j<k.
  - hit(s,k) = i_src_valid_early[s] && i_prod_wr_en[k] && i_prod_rd[k]==i_src_addr_early[s] && !(HAS_X0 && addr==0).
  - Lowest k (youngest producer) wins.
- Also registered per operand: is_x0[s] and the early address. These hold under stall. i_flush (priority over stall) clears sel and src_valid.
- Operand mux, combinational, in priority order:
  1. is_x0 -> 0.
  2. sel[s][k] -> i_fwd_data[k], live, so refreshed load data appears during a stall.
  3. i_lat_wb_en && wb_rd == addr -> i_lat_wb_data.
  4. Otherwise i_rf_data.
- o_stall_req = OR over valid operands of:
  - (sel[s][k] && !i_fwd_data_ready[k]), or
  - (busy[addr] && !sel-any && !(i_lat_wb_en && wb_rd==addr)).
  - Registered select takes precedence over the scoreboard: the younger writer owns the value.
- Scoreboard:
  - At posedge: clear busy[wb_rd] on i_lat_wb_en, then set busy[lat_rd] on accepted issue.
  - Same-edge issue and writeback to the same register leaves busy = 1.
  - Register 0 is never set when HAS_X0.
- o_waw_stall = i_lat_issue && busy[i_lat_rd] && !(i_lat_wb_en && i_lat_wb_rd==i_lat_rd). While asserted, the issue is ignored and the requester holds.
- i_flush does not clear busy bits; in-flight long ops always write back.
- Writeback to a non-busy register is legal (no-op clear).
- Latency: early address to select is 1 cycle; select to o_src_value is 0 cycles.

Test Plan:
- Back-to-back ALU: EX writes x5=0x1234, next instr reads x5 as rs2 → o_src_value[rs2]=0x1234 from slot 0; also in WB same reg with 0xAAAA → slot 0 wins.
- Load-use: slot 0 ready=0 for 3 cycles while x7 selected → o_stall_req=1 for 3 cycles, value updates live, then 0x0BAD_F00D with stall dropping.
- x0: producer writes rd=0 with data 0xFFFF_FFFF, consumer reads x0 → value 0, no stall; with HAS_X0=0 → forwards 0xFFFF_FFFF.
- Scoreboard: issue div to x9; consumer reads x9 → stall until wb cycle, value = wb data in that cycle, busy_vec[9] clears next edge.
- WAW/same-edge: issue to busy x9 → o_waw_stall=1, busy unchanged; issue x9 and wb x9 same edge → busy stays 1.
- Assert i_rst mid-stall with busy bits set → immediately all busy=0, o_stall_req=0, values from i_rf_data.
